// File: rtl/alarm_icon_overlay_if.sv
// Pixel stream and font ROM bus shared by the video timing side and the overlay.
// slave = overlay (pixel/rom_data in, rom_addr/rgbtext out); master = video side.
interface alarm_icon_overlay_if;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] rgbtext;

  modport master (
    output video_on, pix_x, pix_y, rom_data,
    input  rom_addr, rgbtext
  );

  modport slave (
    input  video_on, pix_x, pix_y, rom_data,
    output rom_addr, rgbtext
  );
endinterface

// File: rtl/alarm_icon_overlay.sv
// Alarm bell/wave icon overlay: IDLE/RING/ACKED alarm FSM with blink and timeout,
// plus a 2-cycle pixel pipeline (ROM address, then glyph bit) drawing the icon.
// Ports: clk, reset (sync, active-high), frame_tick, activar_alarma, okmaquina,
// ack, vid (pixel + font ROM bus), ringing, timeout_pulse.
module alarm_icon_overlay #(
  parameter int          X0             = 576,
  parameter int          Y0             = 320,
  parameter int          SCALE_LOG2     = 2,
  parameter logic [3:0]  BELL_CODE      = 4'd7,
  parameter logic [3:0]  WAVE_CODE      = 4'd6,
  parameter int          BLINK_FRAMES   = 30,
  parameter int          TIMEOUT_FRAMES = 1800,
  parameter logic [11:0] COLOR_ON       = 12'hF00
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic activar_alarma,
  input  logic okmaquina,
  input  logic ack,
  alarm_icon_overlay_if.slave vid,
  output logic ringing,
  output logic timeout_pulse
);

  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int SPAN = 16 << SCALE_LOG2;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_FRAMES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [9:0]  X_BEG = 10'(X0);
  localparam logic [9:0]  Y_BEG = 10'(Y0);
  localparam logic [10:0] X_END = 11'(X0 + SPAN);
  localparam logic [10:0] Y_END = 11'(Y0 + SPAN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RING  = 2'd1;
  localparam logic [1:0] ACKED = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          act_d;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          rise;
  logic          t_end;

  assign rise    = activar_alarma & ~act_d;
  assign t_end   = frame_tick && (tcnt == T_LAST);
  assign ringing = (state == RING);

  always_comb begin
    state_nxt = state;
    if (!okmaquina) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_nxt = RING;
        RING:    if (ack) state_nxt = ACKED;
                 else if (t_end) state_nxt = IDLE;
        ACKED:   if (!activar_alarma) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // act_d tracks the input even in reset so a level held through
  // reset is not mistaken for a fresh rising edge afterwards.
  always_ff @(posedge clk) begin
    act_d <= activar_alarma;
    if (reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      phase         <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      timeout_pulse <= okmaquina && ringing && !ack && t_end;
      if (!ringing && state_nxt == RING) begin
        tcnt  <= '0;
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (ringing && frame_tick) begin
        tcnt <= tcnt + TW'(1);
        if (bcnt == B_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end

  logic [9:0] dx;
  logic [9:0] dy;
  logic       hit;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] glyph;

  assign dx = vid.pix_x - X_BEG;
  assign dy = vid.pix_y - Y_BEG;

  // 11-bit upper bounds let the window run past 1023 and clip naturally.
  assign hit = (vid.pix_x >= X_BEG) && ({1'b0, vid.pix_x} < X_END) &&
               (vid.pix_y >= Y_BEG) && ({1'b0, vid.pix_y} < Y_END);

  assign row   = 4'(dy >> SCALE_LOG2);
  assign col   = 3'(dx >> SCALE_LOG2);
  assign glyph = dx[SCALE_LOG2 + 3] ? WAVE_CODE : BELL_CODE;

  logic       hit1;
  logic       von1;
  logic [2:0] col1;
  logic       hit2;
  logic       von2;
  logic [2:0] col2;

  // Stage 2 copies line up with rom_data, which the ROM returns one
  // cycle after the registered address.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid.rom_addr <= 8'h00;
      hit1         <= 1'b0;
      von1         <= 1'b0;
      col1         <= 3'd0;
      hit2         <= 1'b0;
      von2         <= 1'b0;
      col2         <= 3'd0;
    end else begin
      vid.rom_addr <= hit ? {glyph, row} : 8'h00;
      hit1         <= hit;
      von1         <= vid.video_on;
      col1         <= col;
      hit2         <= hit1;
      von2         <= von1;
      col2         <= col1;
    end
  end

  // Bit 7 is the leftmost column, so column c reads bit ~c.
  assign vid.rgbtext =
    (hit2 && von2 && ringing && phase && vid.rom_data[~col2]) ?
    COLOR_ON : 12'h000;

endmodule

// File: tb/tb_alarm_icon_overlay.sv
// Bench for alarm_icon_overlay: directed cycle table, clipped-window/timeout
// sequence and random traffic, two parameterisations against a reference model.
module tb_alarm_icon_overlay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, frame_tick, activar_alarma, okmaquina, ack;
  logic ring_a, tp_a, ring_b, tp_b;
  logic [9:0] px, py;
  logic von;

  alarm_icon_overlay_if bus_a ();
  alarm_icon_overlay_if bus_b ();

  assign bus_a.pix_x = px;
  assign bus_a.pix_y = py;
  assign bus_a.video_on = von;
  assign bus_b.pix_x = px;
  assign bus_b.pix_y = py;
  assign bus_b.video_on = von;

  alarm_icon_overlay #(
    .BLINK_FRAMES(2), .TIMEOUT_FRAMES(6)
  ) u_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .activar_alarma(activar_alarma), .okmaquina(okmaquina), .ack(ack),
    .vid(bus_a.slave), .ringing(ring_a), .timeout_pulse(tp_a)
  );

  alarm_icon_overlay #(
    .X0(1000), .Y0(1010), .SCALE_LOG2(0),
    .BLINK_FRAMES(1), .TIMEOUT_FRAMES(3)
  ) u_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .activar_alarma(activar_alarma), .okmaquina(okmaquina), .ack(ack),
    .vid(bus_b.slave), .ringing(ring_b), .timeout_pulse(tp_b)
  );

  logic [7:0] rom_mem [256];

  always @(posedge clk) begin
    bus_a.rom_data <= rom_mem[bus_a.rom_addr];
    bus_b.rom_data <= rom_mem[bus_b.rom_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_ACK  = 2;
  localparam int BELL = 7;
  localparam int WAVE = 6;

  int p_x0[2]    = '{576, 1000};
  int p_y0[2]    = '{320, 1010};
  int p_s[2]     = '{2, 0};
  int p_blink[2] = '{2, 1};
  int p_tmo[2]   = '{6, 3};

  typedef struct { int st; bit prev; int ticks; bit tp; } fsm_t;
  typedef struct { bit hit; bit von; int addr; int col; } pix_t;

  fsm_t m[2];
  pix_t s1[2];
  pix_t s2[2];

  function automatic pix_t geo(int i, int x, int y, bit v);
    pix_t g;
    int u, w, dx, dy;
    u = 1 << p_s[i];
    w = 16 * u;
    g = '{1'b0, v, 0, 0};
    if (x >= p_x0[i] && x < p_x0[i] + w &&
        y >= p_y0[i] && y < p_y0[i] + w) begin
      dx = x - p_x0[i];
      dy = y - p_y0[i];
      g.hit = 1'b1;
      g.addr = ((dx < 8 * u) ? BELL : WAVE) * 16 + dy / u;
      g.col = (dx / u) % 8;
    end
    return g;
  endfunction

  function automatic fsm_t fsm_next(int i, fsm_t c);
    fsm_t n = c;
    n.tp = 1'b0;
    if (reset) begin
      n.st = M_IDLE;
      n.ticks = 0;
    end else if (!okmaquina) begin
      n.st = M_IDLE;
    end else begin
      case (c.st)
        M_IDLE: if (activar_alarma && !c.prev) begin
          n.st = M_RING;
          n.ticks = 0;
        end
        M_RING: if (ack) n.st = M_ACK;
          else if (frame_tick) begin
            if (c.ticks + 1 == p_tmo[i]) begin
              n.st = M_IDLE;
              n.tp = 1'b1;
            end else n.ticks = c.ticks + 1;
          end
        default: if (!activar_alarma) n.st = M_IDLE;
      endcase
    end
    n.prev = activar_alarma;
    return n;
  endfunction

  task automatic model_update();
    pix_t blank;
    blank = '{1'b0, 1'b0, 0, 0};
    for (int i = 0; i < 2; i++) begin
      m[i] = fsm_next(i, m[i]);
      s2[i] = reset ? blank : s1[i];
      s1[i] = reset ? blank : geo(i, px, py, von);
    end
  endtask

  task automatic check_inst(int i, int ring, int tp, int addr, int rgb);
    bit e_ring, ph;
    logic [7:0] rb;
    int e_rgb;
    e_ring = (m[i].st == M_RING);
    ph = ((m[i].ticks / p_blink[i]) % 2) == 0;
    rb = rom_mem[s2[i].addr];
    e_rgb = (s2[i].hit && s2[i].von && e_ring && ph && rb[7 - s2[i].col])
            ? 'hF00 : 0;
    chk($sformatf("m%0d.ringing", i), ring, int'(e_ring));
    chk($sformatf("m%0d.timeout_pulse", i), tp, int'(m[i].tp));
    chk($sformatf("m%0d.rom_addr", i), addr, s1[i].hit ? s1[i].addr : 0);
    chk($sformatf("m%0d.rgbtext", i), rgb, e_rgb);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_inst(0, ring_a, tp_a, bus_a.rom_addr, bus_a.rgbtext);
    check_inst(1, ring_b, tp_b, bus_b.rom_addr, bus_b.rgbtext);
  endtask

  task automatic set(bit r, bit o, bit a, bit k, bit t);
    reset = r;
    okmaquina = o;
    activar_alarma = a;
    ack = k;
    frame_tick = t;
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit r, o, a, k, t;
    int x, y;
    bit v;
    bit e_ring, e_tp;
    int e_addr, e_rgb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit o, bit a, bit k, bit t,
                              int x, int y, bit v,
                              bit er, bit et, int ea, int eg);
    vec_t w;
    w = '{r, o, a, k, t, x, y, v, er, et, ea, eg};
    return w;
  endfunction

  localparam int H = 'hF00;

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h80;
    px = 10'd576;
    py = 10'd320;
    von = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m[i] = '{M_IDLE, 1'b0, 0, 1'b0};
      s1[i] = '{1'b0, 1'b0, 0, 0};
      s2[i] = '{1'b0, 1'b0, 0, 0};
    end
    set(1, 1, 0, 0, 0);

    tbl.push_back(mk(1,1,0,0,0, 576,320,1, 0,0,'h00,0));
    tbl.push_back(mk(0,1,0,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,1,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,0,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,0,1,1,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,0,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 0,1,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,0,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,1, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,1,1, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,0,0,0, 608,324,1, 0,0,'h61,0));
    tbl.push_back(mk(0,1,0,0,0, 640,324,1, 0,0,'h00,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(0,1,1,0,0, 640,320,1, 1,0,'h00,H));
    tbl.push_back(mk(0,1,1,0,0, 640,320,1, 1,0,'h00,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,0, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,0, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));
    tbl.push_back(mk(1,1,1,0,0, 576,320,1, 0,0,'h00,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,0,0,0, 576,320,1, 0,0,'h70,0));
    tbl.push_back(mk(0,1,1,0,0, 576,320,1, 1,0,'h70,H));

    foreach (tbl[j]) begin
      set(tbl[j].r, tbl[j].o, tbl[j].a, tbl[j].k, tbl[j].t);
      px = 10'(tbl[j].x);
      py = 10'(tbl[j].y);
      von = tbl[j].v;
      step();
      chk($sformatf("tbl[%0d].ringing", j), ring_a, int'(tbl[j].e_ring));
      chk($sformatf("tbl[%0d].timeout_pulse", j), tp_a, int'(tbl[j].e_tp));
      chk($sformatf("tbl[%0d].rom_addr", j), bus_a.rom_addr, tbl[j].e_addr);
      chk($sformatf("tbl[%0d].rgbtext", j), bus_a.rgbtext, tbl[j].e_rgb);
    end

    // Clipped window corner and 3-frame timeout on the second instance.
    set(1, 1, 0, 0, 0);
    px = 10'd1015;
    py = 10'd1023;
    von = 1'b1;
    step();
    set(0, 1, 0, 0, 0);
    step();
    chk("b_clip_addr", bus_b.rom_addr, 'h6D);
    set(0, 1, 1, 0, 0);
    step();
    chk("b_trigger", ring_b, 1);
    for (int k = 1; k <= 3; k++) begin
      set(0, 1, 1, 0, 1);
      step();
      chk($sformatf("b_tick%0d_tp", k), tp_b, int'(k == 3));
      chk($sformatf("b_tick%0d_ring", k), ring_b, int'(k < 3));
    end
    set(0, 1, 1, 0, 0);
    step();
    chk("b_tp_single", tp_b, 0);
    px = 10'd1016;
    step();
    chk("b_out_addr", bus_b.rom_addr, 0);

    // Random traffic against the model.
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(299) == 0);
      okmaquina = ($urandom_range(39) != 0);
      if ($urandom_range(7) == 0) activar_alarma = ~activar_alarma;
      ack = ($urandom_range(15) == 0);
      frame_tick = ($urandom_range(2) == 0);
      von = ($urandom_range(9) != 0);
      case ($urandom_range(2))
        0: begin
          px = 10'(560 + $urandom_range(99));
          py = 10'(310 + $urandom_range(89));
        end
        1: begin
          px = 10'(990 + $urandom_range(33));
          py = 10'(1000 + $urandom_range(23));
        end
        default: begin
          px = 10'($urandom_range(1023));
          py = 10'($urandom_range(1023));
        end
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_icon_overlay.md
ALARM_ICON_OVERLAY -- requirements
Module: alarm_icon_overlay

Interface
REQ-001 Parameter X0, default 576, left pixel column of the icon window.
REQ-002 Parameter Y0, default 320, top pixel row of the icon window.
REQ-003 Parameter SCALE_LOG2, default 2, legal range 0..3, glyph magnification 2^SCALE_LOG2.
REQ-004 Parameter BELL_CODE, default 4'd7, and WAVE_CODE, default 4'd6, font glyph codes.
REQ-005 Parameter BLINK_FRAMES, default 30, frames per blink half-period, minimum 1.
REQ-006 Parameter TIMEOUT_FRAMES, default 1800, frames before auto-stop, minimum 1.
REQ-007 Parameter COLOR_ON, default 12'hF00, RGB of lit glyph pixels.
REQ-008 clk  input  1  pixel clock; all state changes on its rising edge.
REQ-009 reset  input  1  reset, synchronous, active-high.
REQ-010 frame_tick  input  1  one-cycle pulse once per video frame.
REQ-011 activar_alarma  input  1  alarm match request level.
REQ-012 okmaquina  input  1  clock machine enabled level; low forces idle.
REQ-013 ack  input  1  user acknowledge, one-cycle pulse.
REQ-014 video_on  input  1  visible-area flag aligned to pix_x/pix_y.
REQ-015 pix_x, pix_y  input  10 each  current pixel coordinates.
REQ-016 rom_addr  output  8  font ROM address {glyph_code[3:0], row[3:0]}.
REQ-017 rom_data  input  8  font row, valid exactly one cycle after rom_addr; bit 7 is leftmost column.
REQ-018 rgbtext  output  12  overlay colour, 0 where not drawn.
REQ-019 ringing  output  1  high while FSM is in RING.
REQ-020 timeout_pulse  output  1  one-cycle pulse when RING ends by timeout.

Function
REQ-021 FSM states IDLE, RING, ACKED.
REQ-022 IDLE->RING when activar_alarma and okmaquina are both high and activar_alarma was low in the previous cycle (rising edge).
REQ-023 RING->ACKED on ack; RING->IDLE when timeout counter reaches TIMEOUT_FRAMES-1 on a frame_tick, asserting timeout_pulse that cycle.
REQ-024 ACKED->IDLE when activar_alarma is low; no re-trigger from ACKED.
REQ-025 okmaquina low forces IDLE next cycle from any state, with priority over ack and timeout; no timeout_pulse.
REQ-026 ack and timeout on the same cycle: ack wins, state ACKED, no timeout_pulse.
REQ-027 Entering RING clears blink counter, timeout counter and sets blink phase to 1.
REQ-028 In RING, each frame_tick increments blink counter; at BLINK_FRAMES-1 it wraps to 0 and phase toggles.
REQ-029 In RING, each frame_tick increments timeout counter (width ceil(log2(TIMEOUT_FRAMES+1)), saturating never required).
REQ-030 Window: X0 <= pix_x < X0+16*2^S, Y0 <= pix_y < Y0+16*2^S, S=SCALE_LOG2; comparisons unsigned 10-bit, window clipped at 1023.
REQ-031 dx=pix_x-X0, dy=pix_y-Y0; row=dy>>S (4 bits); col=(dx>>S)[2:0]; glyph = dx bit (S+3): 0 selects BELL_CODE (left), 1 selects WAVE_CODE (right).
REQ-032 Stage 1 (cycle n+1 after pixel at n): rom_addr registered, plus registered hit, col, video_on.
REQ-033 Stage 2 (cycle n+2): rgbtext = COLOR_ON if stage-1 hit, video_on, ringing, phase=1 and rom_data[7-col]=1; else 0.
REQ-034 Total pixel latency is exactly 2 cycles; integrator delays sync by 2.
REQ-035 rom_addr outside the window holds 8'h00.

Reset
REQ-036 On reset: state IDLE, counters 0, phase 0, rom_addr 0, pipeline registers 0, rgbtext 0, ringing 0, timeout_pulse 0.
REQ-037 Reset mid-RING returns to IDLE next cycle; a still-high activar_alarma does not re-trigger until it falls and rises again.

Verification
REQ-038 Trigger: okmaquina=1, activar_alarma 0->1 -> ringing=1 next cycle; pixel (576,320) with rom_data=8'h80 -> rgbtext=12'hF00 two cycles later.
REQ-039 Blink: BLINK_FRAMES=2, 4 frame_ticks in RING -> phase 1,1,0,0,1 sequence; rgbtext 0 during phase 0.
REQ-040 Timeout: TIMEOUT_FRAMES=3, 3 frame_ticks -> timeout_pulse one cycle on third, state IDLE, ringing=0.
REQ-041 Ack then release: ack -> ACKED, rgbtext 0; activar_alarma held high no re-ring; drop then raise -> RING again.
REQ-042 Geometry: S=2, pix_x=608,pix_y=324 -> rom_addr={WAVE_CODE,4'd1}; pix_x=640 or video_on=0 -> rgbtext 0.
REQ-043 Priority: okmaquina=0 with ack same cycle -> IDLE, no timeout_pulse; reset mid-RING -> all outputs 0.
